// File: rtl/mmio_io_unit.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_unit
// Purpose  : Memory-mapped I/O state for stage 3 of the 3-stage RISC-V core.
//            Holds the cycle and retired-instruction counters, a UART RX
//            buffer and a UART TX holding register.
//            Build option MMIO_RX_FIFO_EN: when defined, the RX buffer is a
//            RX_DEPTH-entry circular FIFO. Otherwise it is a single-entry
//            register with a valid bit, and RX_DEPTH is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_unit #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        io_we,
  input  logic        cpu_rx_pop,
  input  logic        instr_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_data_valid,
  output logic        uart_rx_data_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_data_valid,
  input  logic        uart_tx_data_ready,
  output logic        uart_rx_valid,
  output logic        uart_tx_ready,
  output logic [7:0]  uart_rx_out,
  output logic [31:0] cyc_counter,
  output logic [31:0] instr_counter
);

  // Word offsets (addr[4:2]) of the two writable registers
  localparam logic [2:0] c_off_tx      = 3'b010;  // 0x80000008
  localparam logic [2:0] c_off_cnt_rst = 3'b110;  // 0x80000018

  // Only addr[4:2] and the low store byte take part in decoding
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, addr[31:5], addr[1:0], wdata[31:8]};

  logic w_tx_store;
  logic w_cnt_clear;
  assign w_tx_store  = io_we && (addr[4:2] == c_off_tx);
  assign w_cnt_clear = io_we && (addr[4:2] == c_off_cnt_rst);

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] instr_q, instr_d;

  // Next counter values; a counter-reset store overrides the increment
  always_comb begin
    cyc_d   = cyc_q + 32'd1;
    instr_d = instr_q + {31'd0, instr_retire};
    if (w_cnt_clear) begin
      cyc_d   = '0;
      instr_d = '0;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      instr_q <= instr_d;
    end
  end

  assign cyc_counter   = cyc_q;
  assign instr_counter = instr_q;

  // --------------------------------------------------------------------------
  // TX holding register
  // --------------------------------------------------------------------------
  logic       tx_pending_q, tx_pending_d;
  logic [7:0] tx_data_q, tx_data_d;

  // Latch a store only while free; release once the transmitter takes it
  always_comb begin
    tx_pending_d = tx_pending_q;
    tx_data_d    = tx_data_q;
    if (!tx_pending_q) begin
      if (w_tx_store) begin
        tx_pending_d = 1'b1;
        tx_data_d    = wdata[7:0];
      end
    end else if (uart_tx_data_ready) begin
      tx_pending_d = 1'b0;
    end
  end

  // TX registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pending_q <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      tx_pending_q <= tx_pending_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign uart_tx_data       = tx_data_q;
  assign uart_tx_data_valid = tx_pending_q;
  assign uart_tx_ready      = !tx_pending_q;

  // --------------------------------------------------------------------------
  // RX buffer
  // --------------------------------------------------------------------------
  logic w_rx_full;
  logic w_rx_empty;
  logic w_rx_push;
  logic w_rx_pop;

  assign w_rx_push = uart_rx_data_valid && !w_rx_full;
  assign w_rx_pop  = cpu_rx_pop && !w_rx_empty;

`ifdef MMIO_RX_FIFO_EN
  localparam int c_ptr_w = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [7:0]         rx_mem_q [RX_DEPTH];
  logic [c_ptr_w-1:0] rx_wptr_q, rx_wptr_d;
  logic [c_ptr_w-1:0] rx_rptr_q, rx_rptr_d;
  logic [c_cnt_w-1:0] rx_cnt_q, rx_cnt_d;

  assign w_rx_full  = (rx_cnt_q == c_cnt_w'(RX_DEPTH));
  assign w_rx_empty = (rx_cnt_q == '0);

  // Pointer and occupancy update; pointers wrap at the power-of-two depth
  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (w_rx_push) begin
      rx_wptr_d = rx_wptr_q + c_ptr_w'(1);
    end
    if (w_rx_pop) begin
      rx_rptr_d = rx_rptr_q + c_ptr_w'(1);
    end
    case ({w_rx_push, w_rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + c_cnt_w'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - c_cnt_w'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RX_DEPTH; i++) begin
        rx_mem_q[i] <= '0;
      end
    end else if (w_rx_push) begin
      rx_mem_q[rx_wptr_q] <= uart_rx_data;
    end
  end

  assign uart_rx_out = rx_mem_q[rx_rptr_q];
`else
  // Depth only matters for the FIFO build
  localparam logic [31:0] c_rx_depth_unused = RX_DEPTH;

  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;

  assign w_rx_full  = rx_valid_q;
  assign w_rx_empty = !rx_valid_q;

  // A pop empties the entry; push is only possible while the entry is empty
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (w_rx_pop) begin
      rx_valid_d = 1'b0;
    end else if (w_rx_push) begin
      rx_valid_d = 1'b1;
      rx_data_d  = uart_rx_data;
    end
  end

  // Single-entry RX registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign uart_rx_out = rx_data_q;
`endif

  assign uart_rx_valid      = !w_rx_empty;
  assign uart_rx_data_ready = !w_rx_full;

endmodule
`default_nettype wire

// File: doc/mmio_io_unit.md
# mmio_io_unit

Memory-mapped I/O state block feeding the stage-3 control and writeback logic of the 3-stage RISC-V core. It holds the cycle and retired-instruction counters, buffers received UART bytes, and latches transmit bytes until the UART transmitter accepts them. Stage 3 reads its status, data and counter outputs combinationally, and drives its store and pop strobes.

## Interface
- RX_DEPTH, 4: RX buffer entries when `MMIO_RX_FIFO_EN` is defined; power of two, at least 2.
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- addr  in  32  stage-3 data address
- wdata  in  32  stage-3 store data
- io_we  in  1  stage-3 store into the I/O region (addr[31:30]=2'b10)
- cpu_rx_pop  in  1  stage-3 load from 0x80000004 that retires this cycle
- instr_retire  in  1  non-bubble instruction retires in stage 3 this cycle
- uart_rx_data  in  8  byte from the UART receiver
- uart_rx_data_valid  in  1  receiver byte valid
- uart_rx_data_ready  out  1  block accepts a receiver byte
- uart_tx_data  out  8  byte to the UART transmitter
- uart_tx_data_valid  out  1  transmit byte valid
- uart_tx_data_ready  in  1  transmitter accepts the byte
- uart_rx_valid  out  1  RX buffer non-empty (status bit 1)
- uart_tx_ready  out  1  TX holding register free (status bit 0)
- uart_rx_out  out  8  RX buffer head byte
- cyc_counter  out  32  cycle counter
- instr_counter  out  32  retired-instruction counter

## Operation
- Address map:
  - 0x80000000: status (read by stage 3).
  - 0x80000004: RX data (read).
  - 0x80000008: TX data (write).
  - 0x80000010: cycle counter (read).
  - 0x80000014: instruction counter (read).
  - 0x80000018: counter reset (write, data ignored).
- The block decodes writes only: io_we together with addr[4:2]. Other offsets are ignored.
- cyc_counter: increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
- instr_counter: increments by 1 on each cycle with instr_retire=1 and wraps the same way.
- Counter reset store: both counters become 0 at the next edge. This takes priority over any increment in the same cycle, so the result is 0, not 1.
- TX path: a store to 0x80000008 while uart_tx_ready=1 latches wdata[7:0] and sets tx_pending.
  - uart_tx_data_valid equals tx_pending.
  - tx_pending clears on the edge where uart_tx_data_valid && uart_tx_data_ready.
  - uart_tx_ready equals !tx_pending.
  - A store while tx_pending=1 is dropped; software polls status first.
- RX path:
  - Push: uart_rx_data_valid && uart_rx_data_ready.
  - uart_rx_data_ready equals !full.
  - Pop: cpu_rx_pop && !empty.
  - uart_rx_out is the head entry. It is combinational from storage, so stage 3 reads it in the same cycle as the pop.
  - Pop while empty is ignored, and uart_rx_out is don't-care.
  - Simultaneous push and pop when neither full nor empty: occupancy is unchanged and order is preserved.

## Timing
- Reset values:
  - cyc_counter=0, instr_counter=0.
  - uart_tx_data_valid=0, uart_tx_data=0, uart_tx_ready=1.
  - RX buffer empty: uart_rx_valid=0, uart_rx_data_ready=1, uart_rx_out=0.
- Reset asserted mid-transfer discards the pending TX byte and all RX entries.
- The cycle after a store to 0x80000008: uart_tx_data_valid=1 and uart_tx_ready=0.
- A received byte is visible on uart_rx_valid and uart_rx_out one cycle after the push edge; there is no bypass.
- A pop advances the head at the edge. uart_rx_valid falls the next cycle if the buffer is then empty.
- Counter outputs are registered. A load of cyc_counter returns the value held at the start of that cycle.
- Push while full: ready is already 0, so no transfer occurs and the receiver holds its byte.

## Configuration
- `MMIO_RX_FIFO_EN` defined: the RX buffer is a RX_DEPTH-entry circular FIFO.
  - Read/write pointers are log2(RX_DEPTH) bits and wrap naturally.
  - Occupancy counter is log2(RX_DEPTH)+1 bits.
  - full = (count==RX_DEPTH).
- `MMIO_RX_FIFO_EN` undefined: single-entry register with a valid bit; RX_DEPTH is ignored.
  - full = valid.
  - Push and pop in the same cycle are allowed only when valid=1 and ready=0, so no push happens; the entry clears.

## Test plan
- Reset, then idle 10 cycles: cyc_counter reads 10 and instr_counter reads 0. Assert instr_retire for 3 cycles: instr_counter reads 3.
- Force cyc_counter to 0xFFFFFFFF: next cycle it reads 0. Store to 0x80000018 with instr_retire=1: both counters read 0 the next cycle.
- Store 0x41 to 0x80000008 with uart_tx_data_ready=0 for 5 cycles: uart_tx_data_valid=1 and uart_tx_data=0x41 throughout, uart_tx_ready=0. Store 0x42 during the wait: it is dropped. Raise ready: valid clears next cycle and only 0x41 is transferred.
- FIFO build: push 0x10, 0x11, 0x12, 0x13: uart_rx_data_ready=0 after the 4th. Pop 4 times: bytes come out in order 0x10..0x13 and uart_rx_valid=0 afterwards. Pop while empty: no change.
- Simultaneous push 0x20 and pop with occupancy 2: occupancy stays 2 and order is preserved across pointer wrap-around.
- Non-FIFO build: push 0x55; a second byte is back-pressured until the pop. Assert rst mid-TX: uart_tx_data_valid=0 and uart_tx_ready=1 the next cycle.
